mem_port_arbiter: RTL and testbench

Round-robin arbiter that shares one 32-bit word-wide memory port between `NUM_REQ` cache-side requesters, such as per-core L1 instruction and data cache refill engines. Each requester uses the same hold-request / wait-for-ready word handshake as the caches. The arbiter registers a one-hot grant and forwards the granted requester's address, write data and control to memory. It routes `mem_ready` back to the granted requester only, and optionally locks the grant for a multi-beat line refill.

---
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 32-bit word memory port among NUM_REQ requesters.
// Define MEM_ARB_BURST_LOCK_EN to hold a grant for up to BURST_LEN beats (line refill lock).
module mem_port_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      i_req,
  input  logic [NUM_REQ-1:0]      i_req_we,
  input  logic [32*NUM_REQ-1:0]   i_req_addr,
  input  logic [32*NUM_REQ-1:0]   i_req_wdata,
  output logic [NUM_REQ-1:0]      o_req_ready,
  output logic [31:0]             o_req_rdata,
  output logic [NUM_REQ-1:0]      o_grant,
  output logic                    o_mem_req,
  output logic                    o_mem_we,
  output logic [31:0]             o_mem_addr,
  output logic [31:0]             o_mem_wdata,
  input  logic [31:0]             i_mem_rdata,
  input  logic                    i_mem_ready
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [IDX_W-1:0]   r_last;
  logic [CNT_W-1:0]   r_beat_cnt;

  logic [31:0]        w_addr_arr  [NUM_REQ];
  logic [31:0]        w_wdata_arr [NUM_REQ];
  logic [IDX_W-1:0]   w_gidx;
  logic [IDX_W-1:0]   w_pick;
  logic [IDX_W-1:0]   w_scan;
  logic               w_found;
  logic               w_hit;
  logic               w_accept;
  logic               w_release;
  logic [CNT_W-1:0]   w_beat_nxt;

  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_addr_arr[gi]  = i_req_addr[32*gi +: 32];
    assign w_wdata_arr[gi] = i_req_wdata[32*gi +: 32];
  end

  // Grant is one-hot, so OR-ing the indices of set bits yields the granted index.
  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_gidx = w_gidx | (r_grant[i] ? IDX_W'(i) : '0);
    end
  end

  // Round-robin scan starting just after the last granted requester.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_last;
    w_scan  = '0;
    w_hit   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_scan  = IDX_W'((int'(r_last) + k) % NUM_REQ);
      w_hit   = ~w_found & i_req[w_scan];
      w_pick  = w_hit ? w_scan : w_pick;
      w_found = w_found | w_hit;
    end
  end

  // Memory-side mux and ready/data return; zero-latency path while a grant is held.
  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = 32'd0;
    o_mem_wdata = 32'd0;
    o_req_ready = '0;
    o_req_rdata = 32'd0;
    if (r_state == ST_BUSY) begin
      o_mem_req   = i_req[w_gidx];
      o_mem_we    = i_req_we[w_gidx];
      o_mem_addr  = w_addr_arr[w_gidx];
      o_mem_wdata = w_wdata_arr[w_gidx];
      o_req_ready = r_grant & i_req & {NUM_REQ{i_mem_ready}};
      o_req_rdata = i_mem_rdata;
    end else begin
      o_mem_req   = 1'b0;
      o_req_ready = '0;
    end
  end

  assign w_accept   = o_mem_req & i_mem_ready;
  assign w_beat_nxt = r_beat_cnt + CNT_W'(1);
  assign o_grant    = r_grant;

  // A withdrawn request always ends the grant; an accepted beat ends it unless the burst is locked.
  always_comb begin
`ifdef MEM_ARB_BURST_LOCK_EN
    if (w_accept) begin
      w_release = (w_beat_nxt == CNT_W'(BURST_LEN));
    end else begin
      w_release = ~i_req[w_gidx];
    end
`else
    w_release = w_accept | ~i_req[w_gidx];
`endif
  end

  // Arbitration FSM: IDLE picks a requester, BUSY forwards its beats until release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_last     <= IDX_W'(NUM_REQ - 1);
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state    <= ST_BUSY;
            r_grant    <= ONE_HOT_0 << w_pick;
            r_last     <= w_pick;
            r_beat_cnt <= '0;
          end else begin
            r_grant    <= '0;
          end
        end
        ST_BUSY: begin
          if (w_accept) begin
            r_beat_cnt <= w_beat_nxt;
          end else begin
            r_beat_cnt <= r_beat_cnt;
          end
          if (w_release) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
          end else begin
            r_state <= ST_BUSY;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model plus directed scenarios.
// Expectations follow MEM_ARB_BURST_LOCK_EN when it is defined for the build.
module tb_mem_port_arbiter;

  localparam int N  = 4;
  localparam int BL = 4;
`ifdef MEM_ARB_BURST_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif
  // Served-requester sequences, first beat in the lowest nibble.
  localparam logic [63:0] T2_SEQ   = LOCK ? 64'h0000_0000_1111_0000 : 64'h0000_0000_1010_1010;
  localparam logic [63:0] T3_SEQ   = LOCK ? 64'h0000_2222_2233_2222 : 64'h0000_2222_2222_3232;
  localparam logic [3:0]  T4_GRANT = LOCK ? 4'b0010 : 4'b0000;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req, req_we, req_ready, grant;
  logic [32*N-1:0] req_addr, req_wdata;
  logic [31:0]     req_rdata, mem_addr, mem_wdata, mem_rdata;
  logic            mem_req, mem_we, mem_ready;

  mem_port_arbiter #(.NUM_REQ(N), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(req), .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_req_ready(req_ready), .o_req_rdata(req_rdata), .o_grant(grant),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .i_mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int          rem [N];
  logic [31:0] addr_v [N];
  logic [N-1:0] done_q;
  logic        acc_q;
  logic        force_rdy;
  int          mcnt, mem_delay;
  int          m_owner, m_last, m_beats;
  int          n_pass, n_total;
  int          served_q[$];
  logic [31:0] saddr_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive_bus();
    for (int i = 0; i < N; i++) begin
      req_addr[32*i +: 32]  = addr_v[i];
      req_wdata[32*i +: 32] = addr_v[i] ^ 32'hDEAD_0000;
      req_we[i]             = (i % 2 == 1);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_beats = 0;
  endtask

  // Arbitration rules applied once per rising edge to the inputs held during the cycle.
  task automatic model_step();
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (m_owner < 0 && req[c]) begin
          m_owner = c;
          m_last  = c;
          m_beats = 0;
        end
      end
    end else if (req[m_owner] && mem_ready) begin
      m_beats++;
      if (!LOCK || m_beats == BL) m_owner = -1;
    end else if (!req[m_owner]) begin
      m_owner = -1;
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] e_grant, e_rdy;
    logic         e_req, e_we;
    logic [31:0]  e_addr, e_wd;
    e_grant = '0; e_rdy = '0; e_req = 1'b0; e_we = 1'b0; e_addr = 32'd0; e_wd = 32'd0;
    if (m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      e_req            = req[m_owner];
      e_we             = (m_owner % 2 == 1);
      e_addr           = addr_v[m_owner];
      e_wd             = addr_v[m_owner] ^ 32'hDEAD_0000;
      e_rdy[m_owner]   = req[m_owner] & mem_ready;
      chk("req_rdata", req_rdata, mem_rdata);
    end
    chk("grant", 32'(grant), 32'(e_grant));
    chk("mem_req", 32'(mem_req), 32'(e_req));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
  endtask

  // One clock: model edge update, requester and memory reactions, then negedge compare.
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    for (int i = 0; i < N; i++) begin
      if (done_q[i] && rem[i] > 0) begin
        rem[i]--;
        addr_v[i] += 32'd4;
      end
      req[i] = (rem[i] > 0);
    end
    drive_bus();
    #1;
    if (force_rdy) begin
      mem_ready = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
    end else begin
      if (acc_q) mcnt = 0;
      if (mem_req) begin
        mcnt++;
        mem_ready = (mcnt >= mem_delay);
      end else begin
        mcnt = 0;
        mem_ready = 1'b0;
      end
      mem_rdata = mem_ready ? (mem_addr ^ 32'h5A5A_0000) : 32'd0;
    end
    @(negedge clk);
    compare_all();
    done_q = req_ready;
    acc_q  = mem_req & mem_ready;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        served_q.push_back(i);
        saddr_q.push_back(mem_addr);
      end
    end
  endtask

  task automatic start(input int i, input int n, input logic [31:0] base);
    rem[i]    = n;
    addr_v[i] = base;
  endtask

  task automatic clear_log();
    served_q.delete();
    saddr_q.delete();
  endtask

  function automatic bit all_done();
    bit d;
    d = (req == '0) && (m_owner < 0);
    for (int i = 0; i < N; i++) if (rem[i] != 0) d = 1'b0;
    return d;
  endfunction

  task automatic run_until_idle(input string name, input int maxc);
    int k;
    bit ok;
    k = 0;
    ok = 1'b0;
    while (k < maxc && !ok) begin
      cycle();
      k++;
      ok = all_done();
    end
    chk({name, "_settled"}, 32'(ok), 32'd1);
  endtask

  task automatic check_order(input string name, input int cnt, input logic [63:0] seq);
    chk({name, "_count"}, served_q.size(), cnt);
    for (int i = 0; i < cnt && i < served_q.size(); i++)
      chk($sformatf("%s_beat%0d", name, i), served_q[i], {28'd0, seq[4*i +: 4]});
  endtask

  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_now_grant", 32'(grant), 32'd0);
    chk("rst_now_mem_req", 32'(mem_req), 32'd0);
    chk("rst_now_req_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < N; i++) rem[i] = 0;
    req = '0; done_q = '0; acc_q = 1'b0; mcnt = 0;
    mem_ready = 1'b0; mem_rdata = 32'd0; force_rdy = 1'b0;
    drive_bus();
    cycle();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_pass = 0; n_total = 0;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_rdata = 32'd0; force_rdy = 1'b0;
    done_q = '0; acc_q = 1'b0; mcnt = 0; mem_delay = 1;
    for (int i = 0; i < N; i++) begin rem[i] = 0; addr_v[i] = 32'd0; end
    drive_bus();
    model_reset();
    cycle();
    cycle();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    #2 rst_n = 1'b1;

    // Single requester, 4-word refill at 0x100, ready in the second cycle of each beat.
    clear_log();
    mem_delay = 2;
    start(0, 4, 32'h100);
    cycle();
    chk("t1_grant_req_cycle", 32'(grant), 32'd0);
    cycle();
    chk("t1_grant_next_cycle", 32'(grant), 32'h1);
    chk("t1_mem_req", 32'(mem_req), 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    run_until_idle("t1", 60);
    check_order("t1", 4, 64'h0);
    for (int i = 0; i < 4 && i < saddr_q.size(); i++)
      chk($sformatf("t1_addr%0d", i), saddr_q[i], 32'h100 + 32'(4 * i));
    chk("t1_grant_end", 32'(grant), 32'd0);

    // Requesters 0 and 1 together from reset, then a second tie.
    do_reset();
    clear_log();
    mem_delay = 1;
    start(0, 4, 32'h200);
    start(1, 4, 32'h300);
    run_until_idle("t2a", 80);
    check_order("t2a", 8, T2_SEQ);
    clear_log();
    start(0, 4, 32'h240);
    start(1, 4, 32'h340);
    run_until_idle("t2b", 80);
    check_order("t2b", 8, T2_SEQ);

    // Requester 2 wants 10 beats while requester 3 waits for 2.
    clear_log();
    start(2, 10, 32'h400);
    cycle();
    start(3, 2, 32'h500);
    run_until_idle("t3", 120);
    check_order("t3", 12, T3_SEQ);

    // Requester 1 withdraws after 2 beats.
    clear_log();
    mem_delay = 2;
    start(1, 2, 32'h600);
    begin
      int k;
      k = 0;
      while (k < 30 && served_q.size() < 2) begin cycle(); k++; end
      chk("t4_two_beats", served_q.size(), 32'd2);
    end
    cycle();
    chk("t4_grant_after_drop", 32'(grant), 32'(T4_GRANT));
    chk("t4_mem_req_after_drop", 32'(mem_req), 32'd0);
    run_until_idle("t4", 20);
    check_order("t4", 2, 64'h11);

    // Ready while no request is outstanding is ignored.
    clear_log();
    force_rdy = 1'b1;
    cycle(); cycle(); cycle();
    chk("t5_grant", 32'(grant), 32'd0);
    chk("t5_req_ready", 32'(req_ready), 32'd0);
    force_rdy = 1'b0;
    cycle();
    check_order("t5", 0, 64'h0);

    // Reset mid-beat, then requester 0 beats requester 3 in a tie.
    clear_log();
    mem_delay = 2;
    start(0, 4, 32'h700);
    cycle(); cycle();
    chk("t6_busy_before_reset", 32'(grant), 32'h1);
    do_reset();
    clear_log();
    mem_delay = 1;
    start(0, 1, 32'h800);
    start(3, 1, 32'h900);
    run_until_idle("t6", 30);
    check_order("t6", 2, 64'h30);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
